// File: rtl/card_pkg.sv
// card_pkg: shared deck constants, the card record and dealer states
// for the card dealer and any display logic that decodes card indices.
package card_pkg;

  localparam logic [5:0] NUM_CARDS      = 6'd52;
  localparam logic [5:0] CARDS_PER_SUIT = 6'd13;
  localparam logic [5:0] LAST_INDEX     = 6'd51;

  typedef struct packed {
    logic [3:0] rank;
    logic [1:0] suit;
    logic [4:0] points;
  } card_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROBE   = 2'd1,
    PRESENT = 2'd2
  } dealer_state_t;

  // Blackjack value: ace is configurable, face cards count ten.
  function automatic logic [4:0] rank_points(input logic [3:0] rank,
                                             input logic [4:0] ace_points);
    if (rank == 4'd1)
      return ace_points;
    else if (rank <= 4'd10)
      return {1'b0, rank};
    else
      return 5'd10;
  endfunction

  // Folds a 6-bit random sample (0..63) onto the 0..51 slot range.
  function automatic logic [5:0] fold_index(input logic [5:0] r);
    return (r >= NUM_CARDS) ? (r - NUM_CARDS) : r;
  endfunction

  function automatic logic [5:0] next_index(input logic [5:0] idx);
    return (idx == LAST_INDEX) ? 6'd0 : (idx + 6'd1);
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// card_dealer_if: deal request / card presentation bundle between the dealer
// and the game FSM. o_probe_cycles exists only with DEALER_PROBE_COUNT_EN.
interface card_dealer_if #(
  parameter int RAND_WIDTH = 16
);

  logic [RAND_WIDTH-1:0] i_rand;
  logic                  i_deal_req;
  logic                  i_shuffle;
  logic                  i_ready;
  logic                  o_card_valid;
  logic [3:0]            o_card_rank;
  logic [1:0]            o_card_suit;
  logic [4:0]            o_card_points;
  logic [5:0]            o_cards_left;
  logic                  o_deck_empty;
  logic                  o_busy;
`ifdef DEALER_PROBE_COUNT_EN
  logic [5:0]            o_probe_cycles;
`endif

  modport master (
    input  i_rand,
    input  i_deal_req,
    input  i_shuffle,
    input  i_ready,
    output o_card_valid,
    output o_card_rank,
    output o_card_suit,
    output o_card_points,
    output o_cards_left,
    output o_deck_empty,
    output o_busy
`ifdef DEALER_PROBE_COUNT_EN
    , output o_probe_cycles
`endif
  );

  modport slave (
    output i_rand,
    output i_deal_req,
    output i_shuffle,
    output i_ready,
    input  o_card_valid,
    input  o_card_rank,
    input  o_card_suit,
    input  o_card_points,
    input  o_cards_left,
    input  o_deck_empty,
    input  o_busy
`ifdef DEALER_PROBE_COUNT_EN
    , input o_probe_cycles
`endif
  );

endinterface

// File: rtl/card_decode.sv
// card_decode: maps a deck slot index (0..51) to rank, suit and point value.
// Purely combinational so display logic can reuse it.
module card_decode
  import card_pkg::*;
#(
  parameter logic [4:0] ACE_POINTS = 5'd1
) (
  input  logic [5:0] idx,
  output card_t      card
);

  logic [1:0] suit;
  logic [3:0] offset;
  logic [3:0] rank;

  // Only the low nibble of idx - suit*13 matters since the remainder is < 13.
  always_comb begin
    suit   = 2'd0;
    offset = 4'd0;
    if (idx < CARDS_PER_SUIT) begin
      suit   = 2'd0;
      offset = idx[3:0];
    end else if (idx < 6'd26) begin
      suit   = 2'd1;
      offset = idx[3:0] - 4'd13;
    end else if (idx < 6'd39) begin
      suit   = 2'd2;
      offset = idx[3:0] - 4'd10;
    end else begin
      suit   = 2'd3;
      offset = idx[3:0] - 4'd7;
    end
    rank = offset + 4'd1;
  end

  always_comb begin
    card        = '0;
    card.rank   = rank;
    card.suit   = suit;
    card.points = rank_points(rank, ACE_POINTS);
  end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: deals cards without replacement, resolving collisions by linear
// probing one slot per cycle. Define DEALER_PROBE_COUNT_EN for o_probe_cycles.
module card_dealer
  import card_pkg::*;
#(
  parameter int         RAND_WIDTH = 16,
  parameter logic [4:0] ACE_POINTS = 5'd1
) (
  input logic           i_clk,
  input logic           i_reset,
  card_dealer_if.master bus
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_PROBE   = PROBE;
  localparam logic [1:0] S_PRESENT = PRESENT;

  logic [1:0]  state;
  logic [51:0] dealt_mask;
  logic [5:0]  cards_left;
  logic [5:0]  probe_idx;
  logic [5:0]  skip_cnt;
  card_t       card_q;
  card_t       card_next;
  logic        card_valid;
`ifdef DEALER_PROBE_COUNT_EN
  logic [5:0]  probe_cycles;
`endif

  // Only the low six bits of the counter feed the slot choice.
  logic unused_rand;
  assign unused_rand = ^bus.i_rand[RAND_WIDTH-1:6];

  card_decode #(
    .ACE_POINTS (ACE_POINTS)
  ) u_decode (
    .idx  (probe_idx),
    .card (card_next)
  );

  // Shuffle outranks everything except reset; it drops any in-flight deal
  // but leaves the card field registers holding the last card.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      dealt_mask   <= '0;
      cards_left   <= NUM_CARDS;
      probe_idx    <= '0;
      skip_cnt     <= '0;
      card_q       <= '0;
      card_valid   <= 1'b0;
`ifdef DEALER_PROBE_COUNT_EN
      probe_cycles <= '0;
`endif
    end else if (bus.i_shuffle) begin
      state        <= S_IDLE;
      dealt_mask   <= '0;
      cards_left   <= NUM_CARDS;
      skip_cnt     <= '0;
      card_valid   <= 1'b0;
`ifdef DEALER_PROBE_COUNT_EN
      probe_cycles <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_deal_req && (cards_left != 6'd0)) begin
            probe_idx <= fold_index(bus.i_rand[5:0]);
            skip_cnt  <= '0;
            state     <= S_PROBE;
          end
        end
        S_PROBE: begin
          // Entered only with a free slot somewhere, so this always ends.
          if (!dealt_mask[probe_idx]) begin
            dealt_mask[probe_idx] <= 1'b1;
            cards_left            <= cards_left - 6'd1;
            card_q                <= card_next;
            card_valid            <= 1'b1;
            state                 <= S_PRESENT;
`ifdef DEALER_PROBE_COUNT_EN
            probe_cycles          <= skip_cnt;
`endif
          end else begin
            probe_idx <= next_index(probe_idx);
            skip_cnt  <= skip_cnt + 6'd1;
          end
        end
        S_PRESENT: begin
          if (bus.i_ready) begin
            card_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          card_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_card_valid  = card_valid;
  assign bus.o_card_rank   = card_q.rank;
  assign bus.o_card_suit   = card_q.suit;
  assign bus.o_card_points = card_q.points;
  assign bus.o_cards_left  = cards_left;
  assign bus.o_deck_empty  = (cards_left == 6'd0);
  assign bus.o_busy        = (state != S_IDLE);
`ifdef DEALER_PROBE_COUNT_EN
  assign bus.o_probe_cycles = probe_cycles;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed checks of card_dealer dealing, probing, handshake,
// shuffle and empty-deck behaviour; DEALER_PROBE_COUNT_EN adds probe counts.
module tb_card_dealer;

  localparam logic [4:0] ACE_PTS = 5'd11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  card_dealer_if #(.RAND_WIDTH(16)) bus ();

  card_dealer #(
    .RAND_WIDTH (16),
    .ACE_POINTS (ACE_PTS)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Holds the given inputs across one rising edge, then returns pulses to 0.
  task automatic apply_stimulus(input logic [15:0] r, input logic req,
                                input logic shf, input logic rdy);
    bus.i_rand     = r;
    bus.i_deal_req = req;
    bus.i_shuffle  = shf;
    bus.i_ready    = rdy;
    @(negedge clk);
    bus.i_deal_req = 1'b0;
    bus.i_shuffle  = 1'b0;
    bus.i_ready    = 1'b0;
  endtask

  task automatic start_deal(input logic [15:0] r, output int lat);
    apply_stimulus(r, 1'b1, 1'b0, 1'b0);
    lat = 0;
    while (!bus.o_card_valid && lat < 60) begin
      apply_stimulus(r, 1'b0, 1'b0, 1'b0);
      lat++;
    end
  endtask

  task automatic accept_card(input string tag);
    apply_stimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    check_output({tag, "_valid_drop"}, bus.o_card_valid, 0);
  endtask

  task automatic deal_card(input string tag, input logic [15:0] r,
                           input int rank, input int suit, input int pts,
                           input int exp_lat);
    int lat;
    start_deal(r, lat);
    check_output({tag, "_latency"}, lat, exp_lat);
    check_output({tag, "_rank"}, bus.o_card_rank, rank);
    check_output({tag, "_suit"}, bus.o_card_suit, suit);
    check_output({tag, "_points"}, bus.o_card_points, pts);
    accept_card(tag);
  endtask

  initial begin
    int          lat;
    int          dups;
    int          bad;
    int          key;
    int          exp_pts;
    logic [51:0] seen;

    bus.i_rand     = '0;
    bus.i_deal_req = 1'b0;
    bus.i_shuffle  = 1'b0;
    bus.i_ready    = 1'b0;
    repeat (2) @(negedge clk);

    check_output("rst_valid", bus.o_card_valid, 0);
    check_output("rst_rank", bus.o_card_rank, 0);
    check_output("rst_suit", bus.o_card_suit, 0);
    check_output("rst_points", bus.o_card_points, 0);
    check_output("rst_cards_left", bus.o_cards_left, 52);
    check_output("rst_empty", bus.o_deck_empty, 0);
    check_output("rst_busy", bus.o_busy, 0);
`ifdef DEALER_PROBE_COUNT_EN
    check_output("rst_probe", bus.o_probe_cycles, 0);
`endif

    reset = 1'b0;
    repeat (2) apply_stimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    check_output("post_rst_busy", bus.o_busy, 0);
    check_output("post_rst_left", bus.o_cards_left, 52);

    $display("[TB] first deal and held presentation");
    apply_stimulus(16'h0005, 1'b1, 1'b0, 1'b0);
    check_output("first_busy", bus.o_busy, 1);
    check_output("first_early_valid", bus.o_card_valid, 0);
    apply_stimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    check_output("first_valid", bus.o_card_valid, 1);
    check_output("first_rank", bus.o_card_rank, 6);
    check_output("first_suit", bus.o_card_suit, 0);
    check_output("first_points", bus.o_card_points, 6);
    check_output("first_left", bus.o_cards_left, 51);
`ifdef DEALER_PROBE_COUNT_EN
    check_output("first_probe", bus.o_probe_cycles, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(16'h0009, (i == 2), 1'b0, 1'b0);
      check_output("hold_valid", bus.o_card_valid, 1);
      check_output("hold_rank", bus.o_card_rank, 6);
      check_output("hold_suit", bus.o_card_suit, 0);
      check_output("hold_left", bus.o_cards_left, 51);
    end
    accept_card("first");
    check_output("first_idle", bus.o_busy, 0);
    apply_stimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    check_output("no_queued_req", bus.o_busy, 0);
    check_output("no_queued_left", bus.o_cards_left, 51);

    $display("[TB] collisions and folding");
    deal_card("coll6", 16'h0005, 7, 0, 7, 2);
`ifdef DEALER_PROBE_COUNT_EN
    check_output("coll6_probe", bus.o_probe_cycles, 1);
`endif
    deal_card("fold3", 16'h0037, 4, 0, 4, 1);
    deal_card("high_bits", 16'hFFC5, 8, 0, 8, 3);
    check_output("left_48", bus.o_cards_left, 48);

    $display("[TB] wrap-around and point values");
    apply_stimulus(16'h0000, 1'b0, 1'b1, 1'b0);
    check_output("shuf_left", bus.o_cards_left, 52);
    deal_card("king", 16'h0033, 13, 3, 10, 1);
    deal_card("ace", 16'h0000, 1, 0, ACE_PTS, 1);
    deal_card("wrap1", 16'h0033, 2, 0, 2, 3);
    deal_card("ten_hearts", 16'h0016, 10, 1, 10, 1);
    apply_stimulus(16'h0000, 1'b0, 1'b1, 1'b0);
    deal_card("king_again", 16'h0033, 13, 3, 10, 1);
    deal_card("wrap0", 16'h0033, 1, 0, ACE_PTS, 2);

    $display("[TB] full deck");
    apply_stimulus(16'h0000, 1'b0, 1'b1, 1'b0);
    seen = '0;
    dups = 0;
    bad  = 0;
    for (int i = 0; i < 52; i++) begin
      start_deal(16'($urandom), lat);
      if (bus.o_card_valid && bus.o_card_rank >= 4'd1 && bus.o_card_rank <= 4'd13) begin
        key = int'(bus.o_card_suit) * 13 + int'(bus.o_card_rank) - 1;
        if (seen[key]) dups++;
        seen[key] = 1'b1;
        exp_pts = (bus.o_card_rank == 4'd1) ? int'(ACE_PTS) :
                  (bus.o_card_rank <= 4'd10) ? int'(bus.o_card_rank) : 10;
        check_output("rand_points", bus.o_card_points, exp_pts);
      end else begin
        bad++;
      end
      accept_card("rand");
    end
    check_output("deck_dups", dups, 0);
    check_output("deck_bad", bad, 0);
    check_output("deck_all_seen", &seen, 1);
    check_output("deck_left", bus.o_cards_left, 0);
    check_output("deck_empty", bus.o_deck_empty, 1);
    apply_stimulus(16'h0005, 1'b1, 1'b0, 1'b0);
    check_output("empty_req_busy", bus.o_busy, 0);
    repeat (3) apply_stimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    check_output("empty_req_valid", bus.o_card_valid, 0);
    check_output("empty_req_left", bus.o_cards_left, 0);

    $display("[TB] shuffle during presentation");
    apply_stimulus(16'h0000, 1'b0, 1'b1, 1'b0);
    check_output("shuf2_empty", bus.o_deck_empty, 0);
    deal_card("pre6", 16'h0005, 6, 0, 6, 1);
    start_deal(16'h0005, lat);
    check_output("pre7_latency", lat, 2);
    check_output("pre7_rank", bus.o_card_rank, 7);
`ifdef DEALER_PROBE_COUNT_EN
    check_output("pre7_probe", bus.o_probe_cycles, 1);
`endif
    apply_stimulus(16'h0000, 1'b0, 1'b1, 1'b1);
    check_output("shuf_valid", bus.o_card_valid, 0);
    check_output("shuf_left52", bus.o_cards_left, 52);
    check_output("shuf_busy", bus.o_busy, 0);
    check_output("shuf_rank_held", bus.o_card_rank, 7);
`ifdef DEALER_PROBE_COUNT_EN
    check_output("shuf_probe", bus.o_probe_cycles, 0);
`endif
    deal_card("post_shuf", 16'h0005, 6, 0, 6, 1);

    $display("[TB] reset during probe");
    apply_stimulus(16'h0005, 1'b1, 1'b0, 1'b0);
    check_output("mid_busy", bus.o_busy, 1);
    reset = 1'b1;
    #2;
    check_output("mid_rst_busy", bus.o_busy, 0);
    check_output("mid_rst_valid", bus.o_card_valid, 0);
    check_output("mid_rst_left", bus.o_cards_left, 52);
    @(negedge clk);
    reset = 1'b0;
    deal_card("after_rst", 16'h0005, 6, 0, 6, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
